// File: rtl/dds_pkg.sv
// Shared constants for the DDS phase-to-amplitude path: dither LFSR, quadrant codes,
// midscale helper and the quarter-wave sine generator used to fill the ROM.
package dds_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic int mid(input int w);
    return 1 << (w - 1);
  endfunction

  // round((2^(w-1)-1) * sin((i+0.5)*pi/2^(a+1))), sine by Taylor series over [0, pi/2]
  function automatic int quarter_sine(input int i, input int a, input int w);
    real x;
    real term;
    real sum;
    x    = (real'(i) + 0.5) * 3.14159265358979323846 / real'(2 ** (a + 1));
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return $rtoi(real'(mid(w) - 1) * sum + 0.5);
  endfunction

endpackage

// File: rtl/dds_sine_quarter_rom.sv
// Quarter-wave sine ROM with registered read; this register is pipeline stage S2.
module dds_sine_quarter_rom
  import dds_pkg::*;
#(
  parameter int A = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic [A-1:0] addr,
  output logic [W-2:0] data
);

  localparam int LW = W - 1;

  logic [W-2:0] rom [2**A];

  for (genvar gi = 0; gi < 2**A; gi++) begin : g_rom
    assign rom[gi] = LW'(quarter_sine(gi, A, W));
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/dds_phase_to_amplitude.sv
// Phase word to offset-binary sine amplitude, 3-stage pipeline (mirror, ROM, sign).
// Define DDS_PHASE_DITHER_EN to add LFSR dither to the dropped low phase bits.
module dds_phase_to_amplitude
  import dds_pkg::*;
#(
  parameter int M = 14,
  parameter int A = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [M-1:0] phase,
  input  logic         phase_valid,
  output logic [W-1:0] amp,
  output logic         amp_valid
);

  localparam int F = M - 2 - A;
  localparam logic [W-1:0] MID = W'(mid(W));

  logic         accept;
  logic [M-1:0] phase_eff;
  logic [1:0]   q;
  logic [A-1:0] addr;

  assign accept = en && phase_valid;

`ifdef DDS_PHASE_DITHER_EN
  localparam logic [15:0] DITHER_MASK = 16'((1 << F) - 1);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (accept) begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Modulo-2^M add: a dithered all-ones phase simply wraps into quadrant 0
  assign phase_eff = phase + M'(lfsr_reg & DITHER_MASK);
`else
  assign phase_eff = phase;
`endif

  assign q    = phase_eff[M-1:M-2];
  assign addr = phase_eff[M-3:M-2-A];

  if (F > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^phase_eff[F-1:0];
  end

  // S1: quadrant capture and address mirroring for the falling quarters
  logic [1:0]   q1_reg;
  logic [A-1:0] addr1_reg;
  logic         v1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= accept;
    end
    if (accept) begin
      q1_reg    <= q;
      addr1_reg <= (q == Q1 || q == Q3) ? ~addr : addr;
    end
  end

  // S2: ROM lookup, quadrant carried alongside
  logic [W-2:0] level;
  logic [1:0]   q2_reg;
  logic         v2_reg;

  dds_sine_quarter_rom #(
    .A (A),
    .W (W)
  ) u_rom (
    .clk  (clk),
    .addr (addr1_reg),
    .data (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
    end
    q2_reg <= q1_reg;
  end

  // S3: negative half sits just below midscale so the two halves sum to full scale
  logic [W-1:0] level_ext;
  assign level_ext = {1'b0, level};

  always_ff @(posedge clk) begin
    if (rst) begin
      amp       <= MID;
      amp_valid <= 1'b0;
    end else begin
      amp_valid <= v2_reg;
      if (v2_reg) begin
        amp <= (q2_reg == Q2 || q2_reg == Q3) ? (MID - W'(1) - level_ext) : (MID + level_ext);
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_to_amplitude.sv
// Directed bench for dds_phase_to_amplitude: corner table, full sweep, gaps/enable, mid-flight reset.
module tb_dds_phase_to_amplitude;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_valid = 1'b0;
  logic [13:0] phase = '0;
  logic [7:0]  amp;
  logic        amp_valid;

  dds_phase_to_amplitude #(.M(14), .A(8), .W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase       (phase),
    .phase_valid (phase_valid),
    .amp         (amp),
    .amp_valid   (amp_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] amp;
    int         tag;
  } exp_t;

  typedef struct {
    logic        en;
    logic        pv;
    logic [13:0] phase;
    logic [7:0]  exp_amp;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[12];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] last_amp = 8'h80;
  logic [7:0] sweep_got[1024];

  // Golden sine straight from the table formula, using the simulator's $sin
  function automatic logic [7:0] model_amp(input logic [13:0] ph);
    logic [1:0] q;
    int a;
    int l;
    q = ph[13:12];
    a = int'(ph[11:4]);
    if (q[0]) a = 255 - a;
    l = $rtoi(127.0 * $sin((real'(a) + 0.5) * 3.141592653589793 / 512.0) + 0.5);
    return q[1] ? 8'(127 - l) : 8'(128 + l);
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: cyc %0d got 0x%0h required 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic p, input logic [13:0] ph,
                      input logic [7:0] ex, input int tag);
    exp_t item;
    rst = r;
    en = e;
    phase_valid = p;
    phase = ph;
    if (!r && e && p) begin
      item.due = cyc + 3;
      item.amp = ex;
      item.tag = tag;
      sb.push_back(item);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      sb.delete();
      check("rst_amp", int'(amp), 'h80);
      check("rst_valid", int'(amp_valid), 0);
      last_amp = 8'h80;
    end else if (amp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: cyc %0d got pulse amp 0x%0h required no pulse", cyc, amp);
      end else begin
        item = sb.pop_front();
        $display("[TB] cyc %0d amp 0x%02h expected 0x%02h", cyc, amp, item.amp);
        check("latency", cyc, item.due);
        check("amp", int'(amp), int'(item.amp));
        if (item.tag >= 0) sweep_got[item.tag] = amp;
      end
      last_amp = amp;
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        item = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_valid: cyc %0d got no pulse required amp 0x%0h", cyc, item.amp);
      end
      check("amp_hold", int'(amp), int'(last_amp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 14'h0, 8'h0, -1);
  endtask

  initial begin
    logic [13:0] ph;
    logic        e;
    logic        p;

    vecs[0]  = '{1'b1, 1'b1, 14'h0000, 8'h80};
    vecs[1]  = '{1'b1, 1'b1, 14'h1000, 8'hFF};
    vecs[2]  = '{1'b1, 1'b1, 14'h2000, 8'h7F};
    vecs[3]  = '{1'b1, 1'b1, 14'h3000, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 14'h0800, 8'hDA};
    vecs[5]  = '{1'b1, 1'b0, 14'h1800, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 14'h1800, 8'hDA};
    vecs[7]  = '{1'b1, 1'b1, 14'h2800, 8'h25};
    vecs[8]  = '{1'b0, 1'b1, 14'h0800, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 14'h3800, 8'h25};
    vecs[10] = '{1'b1, 1'b1, 14'h3FFF, 8'h7F};
    vecs[11] = '{1'b1, 1'b1, 14'h0FFF, 8'hFF};

    for (int i = 0; i < 1024; i++) sweep_got[i] = 8'h00;

    // Reset held two cycles, then idle with nothing accepted
    step(1'b1, 1'b0, 1'b0, 14'h0, 8'h0, -1);
    step(1'b1, 1'b0, 1'b0, 14'h0, 8'h0, -1);
    idle(4);

`ifdef DDS_PHASE_DITHER_EN
    begin
      logic [15:0] lfsr_m;
      lfsr_m = 16'hACE1;
      for (int i = 0; i < 64; i++) begin
        ph = 14'h0008 + 14'(lfsr_m & 16'h000F);
        step(1'b0, 1'b1, 1'b1, 14'h0008, model_amp(ph), -1);
        lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      end
      idle(4);
      check("dither_drain", sb.size(), 0);
    end
`else
    // Quadrant corners and mid-quarter points, back-to-back with a gap and an en-low slot
    for (int i = 0; i < 12; i++) begin
      step(1'b0, vecs[i].en, vecs[i].pv, vecs[i].phase, vecs[i].exp_amp, -1);
    end
    idle(4);
    check("table_drain", sb.size(), 0);

    // Full-cycle sweep, then half-cycle complement symmetry
    for (int i = 0; i < 1024; i++) begin
      ph = 14'(i * 16);
      step(1'b0, 1'b1, 1'b1, ph, model_amp(ph), i);
    end
    idle(4);
    check("sweep_drain", sb.size(), 0);
    for (int i = 0; i < 512; i++) begin
      check("symmetry", int'(sweep_got[i]) + int'(sweep_got[i + 512]), 255);
    end

    // Gapped stream with en dropped for 5 clk; in-flight samples must still emerge
    for (int i = 0; i < 40; i++) begin
      e  = !(i >= 15 && i < 20);
      p  = (i % 3) != 1;
      ph = 14'(i * 397);
      step(1'b0, e, p, ph, model_amp(ph), -1);
    end
    idle(4);
    check("gaps_drain", sb.size(), 0);

    // Two samples in flight, then reset: nothing may emerge afterwards
    step(1'b0, 1'b1, 1'b1, 14'h1000, 8'hFF, -1);
    step(1'b0, 1'b1, 1'b1, 14'h0800, 8'hDA, -1);
    step(1'b1, 1'b1, 1'b1, 14'h2000, 8'h00, -1);
    idle(5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
